// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the shared memory port
// seen by mem_port_arbiter. The master modport is the arbiter's view; the
// slave modport is the view of everything around it (requesters + memory).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_done;
  logic              i_err;
  // load/store requester
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_err;
  // unified memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_done, i_err, d_rdata, d_done, d_err,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_done, i_err, d_rdata, d_done, d_err,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch (I) and load/store (D)
// requesters. Round-robin on ties, latched request held on the memory bus
// until mem_ready, one-cycle done pulse, watchdog abort after TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // last BUSY cycle index at which a missing mem_ready triggers the abort
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       last_gnt_d;   // 1 = D was granted most recently
  logic       i_elig, d_elig;
  logic       gnt_i, gnt_d;
  logic       finish, abort;

  // Next-state: grant decision in IDLE, completion/abort decision in BUSY
  always_comb begin
    state_nx = state;
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    // a port whose done is high is dropping its req; do not regrant it
    i_elig   = bus.i_req && !bus.i_done;
    d_elig   = bus.d_req && !bus.d_done;
    case (state)
      IDLE: begin
        if (i_elig && (!d_elig || last_gnt_d)) begin
          gnt_i    = 1'b1;
          state_nx = BUSY_I;
        end else if (d_elig) begin
          gnt_d    = 1'b1;
          state_nx = BUSY_D;
        end
      end
      BUSY_I, BUSY_D: begin
        // ready in the final watchdog cycle still counts as completion
        if (bus.mem_ready)
          finish = 1'b1;
        else if (wait_cnt == WAIT_LAST)
          abort = 1'b1;
        if (finish || abort)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // Control: strobes, done/err pulses, watchdog counter, round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_en <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.i_done <= 1'b0;
      bus.i_err  <= 1'b0;
      bus.d_done <= 1'b0;
      bus.d_err  <= 1'b0;
      wait_cnt   <= '0;
      last_gnt_d <= 1'b1;
    end else begin
      bus.mem_en <= (state_nx != IDLE);
      bus.i_done <= (state == BUSY_I) && (finish || abort);
      bus.i_err  <= (state == BUSY_I) && abort;
      bus.d_done <= (state == BUSY_D) && (finish || abort);
      bus.d_err  <= (state == BUSY_D) && abort;
      if (gnt_i || gnt_d) begin
        wait_cnt   <= '0;
        last_gnt_d <= gnt_d;
        bus.mem_we <= gnt_d && bus.d_we;
      end else if (state != IDLE) begin
        if (!bus.mem_ready)
          wait_cnt <= wait_cnt + 8'd1;
        if (finish || abort)
          bus.mem_we <= 1'b0;
      end
    end
  end

  // Data: request latch on grant, read-data capture or clear on abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
    end else begin
      if (gnt_i)
        bus.mem_addr <= bus.i_addr;
      if (gnt_d) begin
        bus.mem_addr  <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
      end
      if (state == BUSY_I) begin
        if (finish)
          bus.i_rdata <= bus.mem_rdata;
        else if (abort)
          bus.i_rdata <= '0;
      end
      if (state == BUSY_D) begin
        if (finish && !bus.mem_we)
          bus.d_rdata <= bus.mem_rdata;
        else if (abort)
          bus.d_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level model predicts service
// order, memory traffic and returned data; a memory responder/monitor checks
// each access and each done pulse against the queued expectations.
module tb_mem_port_arbiter;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } acc_t;

  typedef struct {
    bit          port_d;
    bit          err;
    logic [31:0] rdata;
  } res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] i_rd_m = 32'h0;
  logic [31:0] d_rd_m = 32'h0;
  bit          last_d_m = 1'b1;
  int          total = 0;
  int          bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(logic [31:0] a);
    if (mem_m.exists(a))
      return mem_m[a];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  // One serviced access: what goes on the memory bus and what comes back.
  task automatic model_access(bit port_d, bit we, logic [31:0] a,
                              logic [31:0] wd, int lat);
    acc_t ac;
    res_t rs;
    bit   ok;
    ok       = (lat < TIMEOUT);
    ac.we    = we;
    ac.addr  = a;
    ac.wdata = wd;
    ac.lat   = lat;
    ac.rdata = we ? $urandom : mem_read(a);
    acc_q.push_back(ac);
    rs.port_d = port_d;
    rs.err    = !ok;
    if (!ok)
      rs.rdata = 32'h0;
    else if (we)
      rs.rdata = d_rd_m;
    else
      rs.rdata = ac.rdata;
    if (port_d) d_rd_m = rs.rdata;
    else        i_rd_m = rs.rdata;
    if (ok && we)
      mem_m[a] = wd;
    res_q.push_back(rs);
    last_d_m = port_d;
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0: return TIMEOUT - 1;
      1: return TIMEOUT + $urandom_range(0, 3);
      2: return TIMEOUT - 2;
      default: return $urandom_range(0, 4);
    endcase
  endfunction

  // Issue requests from an idle arbiter and wait until all of them finish.
  task automatic run_txn(bit use_i, bit use_d, logic [31:0] ia, logic [31:0] da,
                         logic [31:0] dwd, bit dwe, int li, int ld, bit drop_i);
    bit first_d, pend_i, pend_d;
    int cyc;
    first_d = use_d && (!use_i || !last_d_m);
    if (first_d) begin
      model_access(1'b1, dwe, da, dwd, ld);
      if (use_i) model_access(1'b0, 1'b0, ia, 32'h0, li);
    end else begin
      if (use_i) model_access(1'b0, 1'b0, ia, 32'h0, li);
      if (use_d) model_access(1'b1, dwe, da, dwd, ld);
    end
    bus.i_req   = use_i;
    bus.i_addr  = ia;
    bus.d_req   = use_d;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    pend_i = use_i;
    pend_d = use_d;
    @(posedge clk); #1;
    check("grant_latency", {31'h0, bus.mem_en}, 32'h1);
    cyc = 0;
    while ((pend_i || pend_d) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1 && drop_i && use_i && !first_d)
        bus.i_req = 1'b0;
      if (bus.i_done) begin bus.i_req = 1'b0; pend_i = 1'b0; end
      if (bus.d_done) begin bus.d_req = 1'b0; pend_d = 1'b0; end
    end
    if (pend_i || pend_d)
      check("txn_timeout", {30'h0, pend_i, pend_d}, 32'h0);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  // Memory responder and monitor: answers accesses with the planned latency
  // and checks bus contents, access length and every done pulse.
  initial begin
    acc_t cur;
    res_t r;
    int   j;
    bit   prev_en, have, ends, any_done;
    prev_en = 1'b0;
    have    = 1'b0;
    j       = 0;
    cur     = '{default: 0};
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_en = 1'b0;
        have    = 1'b0;
        bus.mem_ready = 1'b0;
        continue;
      end
      ends     = prev_en && !bus.mem_en;
      any_done = bus.i_done || bus.d_done;
      if (any_done || ends)
        check("done_at_access_end", {31'h0, any_done}, {31'h0, ends});
      if (bus.i_done && bus.d_done)
        check("done_exclusive", 32'h1, 32'h0);
      if (ends && have) begin
        check("busy_cycles", j, (cur.lat + 1 < TIMEOUT) ? cur.lat + 1 : TIMEOUT);
        have = 1'b0;
      end
      if (any_done) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", {31'h0, bus.d_done}, 32'hFFFF_FFFF);
        end else begin
          r = res_q.pop_front();
          check("done_port_d", {31'h0, bus.d_done}, {31'h0, r.port_d});
          if (r.port_d) begin
            check("d_err", {31'h0, bus.d_err}, {31'h0, r.err});
            check("d_rdata", bus.d_rdata, r.rdata);
          end else begin
            check("i_err", {31'h0, bus.i_err}, {31'h0, r.err});
            check("i_rdata", bus.i_rdata, r.rdata);
          end
        end
      end
      if (bus.mem_en && !prev_en) begin
        if (acc_q.size() == 0) begin
          check("unexpected_access", bus.mem_addr, 32'hFFFF_FFFF);
          have = 1'b0;
        end else begin
          cur  = acc_q.pop_front();
          have = 1'b1;
          j    = 0;
          check("mem_we", {31'h0, bus.mem_we}, {31'h0, cur.we});
          check("mem_addr", bus.mem_addr, cur.addr);
          if (cur.we)
            check("mem_wdata", bus.mem_wdata, cur.wdata);
        end
      end
      if (bus.mem_en && have) begin
        bus.mem_ready = (j == cur.lat);
        bus.mem_rdata = (j == cur.lat) ? cur.rdata : $urandom;
        j++;
      end else begin
        bus.mem_ready = bus.mem_en;
        bus.mem_rdata = $urandom;
      end
      prev_en = bus.mem_en;
    end
  end

  // Stimulus
  initial begin
    acc_t ac;
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_dones", {30'h0, bus.i_done, bus.d_done}, 32'h0);
    check("rst_errs", {30'h0, bus.i_err, bus.d_err}, 32'h0);
    check("rst_i_rdata", bus.i_rdata, 32'h0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // single fetch with two wait cycles
    mem_m[32'h40] = 32'hDEADBEEF;
    run_txn(1, 0, 32'h40, 32'h0, 32'h0, 0, 2, 0, 0);
    // load then store to the same address; store leaves d_rdata alone
    run_txn(0, 1, 32'h0, 32'h100, 32'h0, 0, 0, 1, 0);
    run_txn(0, 1, 32'h0, 32'h100, 32'h12345678, 1, 0, 0, 0);
    run_txn(0, 1, 32'h0, 32'h100, 32'h0, 0, 0, 1, 0);
    // ties: I first on both, D served in between
    run_txn(1, 1, 32'h44, 32'h104, 32'h0, 0, 1, 0, 0);
    run_txn(1, 1, 32'h48, 32'h108, 32'h0, 0, 0, 3, 0);
    // watchdog abort, and ready in the last allowed cycle
    run_txn(0, 1, 32'h0, 32'h10C, 32'h0, 0, 0, TIMEOUT + 4, 0);
    run_txn(0, 1, 32'h0, 32'h100, 32'h0, 0, 0, TIMEOUT - 1, 0);
    run_txn(1, 0, 32'h50, 32'h0, 32'h0, 0, TIMEOUT + 1, 0, 0);
    // fetch request dropped one cycle into the access
    run_txn(1, 0, 32'h40, 32'h0, 32'h0, 0, 3, 0, 1);

    for (int n = 0; n < 150; n++) begin
      int  kind;
      bit  ui, ud, dr;
      kind = $urandom_range(0, 2);
      ui   = (kind != 1);
      ud   = (kind != 0);
      dr   = ($urandom_range(0, 3) == 0);
      run_txn(ui, ud, {26'h0, 4'($urandom_range(0, 15)), 2'b00},
              {26'h0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
              1'($urandom_range(0, 1)), pick_lat(), pick_lat(), dr);
    end

    // asynchronous reset in the middle of a D load
    ac.we = 1'b0; ac.addr = 32'h3C; ac.wdata = 32'h0; ac.rdata = 32'h0;
    ac.lat = 100;
    acc_q.push_back(ac);
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3C;
    @(posedge clk); #1;
    check("rstmid_grant", {31'h0, bus.mem_en}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rstmid_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rstmid_d_done", {31'h0, bus.d_done}, 32'h0);
    check("rstmid_d_rdata", bus.d_rdata, 32'h0);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    rst = 1'b0;
    last_d_m = 1'b1;
    i_rd_m = 32'h0;
    d_rd_m = 32'h0;
    @(posedge clk); #1;
    // next tie must go to I again
    run_txn(1, 1, 32'h20, 32'h24, 32'h0, 0, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1;
    check("acc_q_drained", acc_q.size(), 32'h0);
    check("res_q_drained", res_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global bound so a stuck DUT cannot hang the run
  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
